rr_mux_arbiter: RTL and testbench
=================================

// Module: rr_mux_arbiter
//
// PURPOSE
// - Shares one N-input data mux between N_REQ requesters using round-robin arbitration.
// - Each requester offers data with a valid/ready handshake. The block picks one winner
//   per cycle, drives the mux select from that winner and registers the mux output in a
//   single-entry output stage with its own valid/ready handshake.
// - Sits between independent producers and one shared downstream consumer.
//
// PARAMETERS
// - N_REQ  4  number of requesters, >= 2
// - W      8  data width per requester
//
// PORTS
// - clk        in   1          clock, all state updates on posedge
// - rst        in   1          synchronous reset, active-high
// - req_valid  in   N_REQ      requester i has data on req_data[i]
// - req_data   in   N_REQ x W  packed array of requester payloads
// - req_ready  out  N_REQ      requester i's word is accepted this cycle
// - out_valid  out  1          output register holds a word
// - out_data   out  W          registered mux output
// - out_src    out  clog2(N_REQ)  index of the requester that produced out_data
// - out_ready  in   1          consumer accepts the word this cycle
//
// BEHAVIOUR
// - Reset (rst=1 at posedge) sets:
//   - out_valid=0, out_data=0, out_src=0
//   - rr_ptr=0, so requester 0 has highest priority first.
//   - req_ready is 0 while out_valid=0 and no req_valid is set.
// - Load enable: load = !out_valid || out_ready. A word may enter the output register
//   in the same cycle the previous word leaves, giving full throughput.
// - Winner selection:
//   - Search for the first req_valid[i], starting at index rr_ptr and wrapping N_REQ-1 -> 0.
//   - Winner is valid if any req_valid is set.
// - req_ready is combinational: req_ready[i] = load && winner_valid && (winner==i).
//   - It is one-hot or all-zero.
//   - It may depend on req_valid. Requesters must not make req_valid depend on req_ready.
// - Transfer: when load && winner_valid, the next edge sets:
//   - out_data <= req_data[winner], out_src <= winner, out_valid <= 1
//   - rr_ptr <= (winner+1) mod N_REQ
// - When load && !winner_valid: out_valid <= 0. out_data, out_src and rr_ptr hold.
// - When !load (output stalled): out_*, rr_ptr and the stored word all hold.
//   - The stored word must be stable until accepted.
//   - All req_ready are 0.
// - Latency: 1 cycle from req handshake to out_valid.
// - Fairness: a continuously valid requester is granted within N_REQ transfers.
// - Boundary: a single requester always valid with out_ready=1 is granted every cycle.
//   rr_ptr passing it does not block it.
// - Reset mid-operation:
//   - An in-flight output word is discarded.
//   - No req_ready is asserted in the reset cycle. Requesters keep their data.
// - Width rules:
//   - rr_ptr and out_src are clog2(N_REQ) bits.
//   - Wrap uses an explicit compare with N_REQ-1, so non-power-of-2 N_REQ is correct.
//
// STRUCTURE
// - Package rr_mux_arb_pkg: default constants (DEF_N_REQ, DEF_W) and a function
//   rr_next(ptr, n) that returns the wrapped increment.
// - Sub-module rr_pick:
//   - Combinational, parameterised by N_REQ.
//   - Inputs: req vector, start pointer. Outputs: winner index, winner_valid.
//   - Built as a double-width rotate plus priority encoder.
// - Top level: rr_pick, the data mux indexed by winner, the output register and the
//   rr_ptr register.
//
// TESTING
// - Reset: hold rst 2 cycles with all req_valid=1
//   -> out_valid=0, req_ready=0 during reset.
//   -> First grant after reset goes to requester 0.
// - Round-robin, N_REQ=4, W=8: all valid, req_data = {8'h33,8'h22,8'h11,8'h00}, out_ready=1
//   -> out_src sequence 0,1,2,3,0 on consecutive cycles.
//   -> out_data 00,11,22,33,00.
// - Sparse: only req 2 valid, then only req 1 valid the next cycle
//   -> grants 2 then 1, back-to-back.
//   -> rr_ptr wraps correctly: grant 1 is not skipped.
// - Backpressure: out_ready=0 for 3 cycles while out_valid=1
//   -> out_data/out_src stable, req_ready=0.
//   -> Release gives one transfer per cycle with no word lost or duplicated
//      (scoreboard on source index + data).
// - Random stress: random req_valid and out_ready over 10k cycles
//   -> every accepted word appears exactly once, in acceptance order.
//   -> No requester waits more than N_REQ grants while continuously valid.
// - Mid-run reset: assert rst while out_valid=1 and out_ready=0
//   -> out_valid=0 next cycle.
//   -> Next grant goes to requester 0.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants and helpers for the round-robin mux arbiter.
package rr_mux_arb_pkg;

  localparam int unsigned DEF_N_REQ = 4;
  localparam int unsigned DEF_W     = 8;

  // Wrapped increment of a round-robin pointer; explicit compare keeps non-power-of-2 counts correct.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    if (ptr == n - 32'd1) begin
      return 32'd0;
    end
    return ptr + 32'd1;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Round-robin winner search: first set request at or after the start pointer, wrapping.
module rr_pick
  import rr_mux_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = DEF_N_REQ,
  localparam int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_start,
  output logic [IW-1:0]    o_winner,
  output logic             o_winner_valid
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [IW-1:0]      w_off;
  logic               w_found;
  logic [IW:0]        w_sum;

  // Rotate so bit 0 is the start index, priority-encode, then map the offset back to an index.
  always_comb begin
    w_dbl   = {i_req, i_req};
    w_rot   = w_dbl[i_start +: N_REQ];
    w_off   = '0;
    w_found = 1'b0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off   = IW'(k);
        w_found = 1'b1;
      end
    end
    w_sum = {1'b0, i_start} + {1'b0, w_off};
    if (w_sum >= (IW+1)'(N_REQ)) begin
      w_sum = w_sum - (IW+1)'(N_REQ);
    end
  end

  assign o_winner       = w_sum[IW-1:0];
  assign o_winner_valid = w_found;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one data mux among requesters, with a registered output stage.
module rr_mux_arbiter
  import rr_mux_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = DEF_N_REQ,
  parameter  int unsigned W     = DEF_W,
  localparam int unsigned IW    = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0][W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      out_valid,
  output logic [W-1:0]              out_data,
  output logic [IW-1:0]             out_src,
  input  logic                      out_ready
);

  logic [IW-1:0] r_rr_ptr;
  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic [IW-1:0] r_out_src;

  logic [IW-1:0] w_winner;
  logic          w_win_valid;
  logic          w_load;
  logic          w_xfer;
  logic [W-1:0]  w_mux;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req          (req_valid),
    .i_start        (r_rr_ptr),
    .o_winner       (w_winner),
    .o_winner_valid (w_win_valid)
  );

  // Load enable, one-hot grant (suppressed during reset) and the shared data mux.
  always_comb begin
    w_load    = !r_out_valid || out_ready;
    w_xfer    = w_load && w_win_valid && !rst;
    w_mux     = req_data[w_winner];
    req_ready = '0;
    if (w_xfer) begin
      req_ready[w_winner] = 1'b1;
    end
  end

  // Output register and round-robin pointer; everything holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_rr_ptr    <= '0;
    end else if (w_load) begin
      if (w_win_valid) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux;
        r_out_src   <= w_winner;
        r_rr_ptr    <= IW'(rr_next(32'(w_winner), N_REQ));
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed vector table plus a reference-model scoreboard.
module tb_rr_mux_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned IW = 2;

  logic                  clk;
  logic                  rst;
  logic [N-1:0]          req_valid;
  logic [N-1:0][W-1:0]   req_data;
  logic [N-1:0]          req_ready;
  logic                  out_valid;
  logic [W-1:0]          out_data;
  logic [IW-1:0]         out_src;
  logic                  out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  rr_mux_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard (runs on every negedge) ----------------
  typedef struct packed {
    logic [IW-1:0] src;
    logic [W-1:0]  data;
  } word_t;

  word_t sb_q[$];
  bit    m_known = 1'b0;
  logic  m_valid;
  int    m_ptr;
  int    waitc[N];

  always @(negedge clk) begin
    bit          m_load;
    bit          m_win_ok;
    int          m_win;
    logic [N-1:0] m_ready;
    word_t       w;
    int          worst;

    m_win_ok = 1'b0;
    m_win    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) begin
        m_win_ok = 1'b1;
        m_win    = idx;
      end
    end
    m_load  = !m_valid || out_ready;
    m_ready = '0;
    if (m_known && m_load && m_win_ok && !rst) m_ready[m_win] = 1'b1;

    if (m_known) begin
      chk("sb_req_ready", 32'(req_ready), 32'(m_ready));
      chk("sb_out_valid", 32'(out_valid), 32'(m_valid));
      if (!rst && m_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_queue_nonempty", 32'd0, 32'd1);
        end else begin
          w = sb_q.pop_front();
          chk("sb_out_src", 32'(out_src), 32'(w.src));
          chk("sb_out_data", 32'(out_data), 32'(w.data));
        end
      end
      // Fairness, observed on the DUT's own grants.
      if (!rst) begin
        worst = 0;
        for (int i = 0; i < N; i++) begin
          if (!req_valid[i] || req_ready[i]) waitc[i] = 0;
          else if (|req_ready) waitc[i] = waitc[i] + 1;
          if (waitc[i] > worst) worst = waitc[i];
        end
        if (|req_ready) chk("sb_fairness_wait_gt_nm1", 32'(worst > N - 1), 32'd0);
      end
    end

    if (rst) begin
      m_known = 1'b1;
      m_valid = 1'b0;
      m_ptr   = 0;
      sb_q.delete();
      for (int i = 0; i < N; i++) waitc[i] = 0;
    end else if (m_known && m_load) begin
      if (m_win_ok) begin
        w.src  = IW'(m_win);
        w.data = req_data[m_win];
        sb_q.push_back(w);
        m_valid = 1'b1;
        m_ptr   = (m_win + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          rst;
    logic [N-1:0]  valid;
    logic          ordy;
    logic [N-1:0]  exp_ready;
    logic          exp_valid;
    logic [IW-1:0] exp_src;
    logic [W-1:0]  exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [N-1:0] v, input logic o, input logic [N-1:0] er,
                     input logic ev, input logic [IW-1:0] es, input logic [W-1:0] ed);
    vec_t t;
    t.rst = r; t.valid = v; t.ordy = o; t.exp_ready = er;
    t.exp_valid = ev; t.exp_src = es; t.exp_data = ed;
    vecs.push_back(t);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) req_data[i] = W'(i * 17);

    // reset held 2 cycles with all requesters valid
    add(1, 4'b1111, 1, 4'b0000, 0, 2'd0, 8'h00);
    add(1, 4'b1111, 1, 4'b0000, 0, 2'd0, 8'h00);
    // round robin 0,1,2,3,0
    add(0, 4'b1111, 1, 4'b0001, 1, 2'd0, 8'h00);
    add(0, 4'b1111, 1, 4'b0010, 1, 2'd1, 8'h11);
    add(0, 4'b1111, 1, 4'b0100, 1, 2'd2, 8'h22);
    add(0, 4'b1111, 1, 4'b1000, 1, 2'd3, 8'h33);
    add(0, 4'b1111, 1, 4'b0001, 1, 2'd0, 8'h00);
    // sparse: req 2 then req 1 (pointer wraps past 3)
    add(0, 4'b0100, 1, 4'b0100, 1, 2'd2, 8'h22);
    add(0, 4'b0010, 1, 4'b0010, 1, 2'd1, 8'h11);
    // backpressure three cycles, then release
    add(0, 4'b1111, 0, 4'b0000, 1, 2'd1, 8'h11);
    add(0, 4'b1111, 0, 4'b0000, 1, 2'd1, 8'h11);
    add(0, 4'b1111, 0, 4'b0000, 1, 2'd1, 8'h11);
    add(0, 4'b1111, 1, 4'b0100, 1, 2'd2, 8'h22);
    add(0, 4'b1111, 1, 4'b1000, 1, 2'd3, 8'h33);
    // idle: output drains, data/src hold
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd3, 8'h33);
    add(0, 4'b0000, 0, 4'b0000, 0, 2'd3, 8'h33);
    // empty register loads even with out_ready=0, then stalls; mid-run reset discards it
    add(0, 4'b1111, 0, 4'b0001, 1, 2'd0, 8'h00);
    add(0, 4'b1111, 0, 4'b0000, 1, 2'd0, 8'h00);
    add(1, 4'b1111, 0, 4'b0000, 0, 2'd0, 8'h00);
    add(0, 4'b1111, 1, 4'b0001, 1, 2'd0, 8'h00);
    add(0, 4'b1010, 1, 4'b0010, 1, 2'd1, 8'h11);
    add(0, 4'b1010, 1, 4'b1000, 1, 2'd3, 8'h33);
    // single requester always valid: granted every cycle across the wrap
    add(0, 4'b0001, 1, 4'b0001, 1, 2'd0, 8'h00);
    add(0, 4'b0001, 1, 4'b0001, 1, 2'd0, 8'h00);
    add(0, 4'b0001, 1, 4'b0001, 1, 2'd0, 8'h00);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst       = vecs[i].rst;
      req_valid = vecs[i].valid;
      out_ready = vecs[i].ordy;
      #3;
      chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_out_src", i), 32'(out_src), 32'(vecs[i].exp_src));
      chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
    end

    // random stress; the negedge scoreboard does the checking
    rst = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      req_valid = N'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) req_data[i] = W'($urandom);
      if (c == 5000) begin
        rst       = 1'b1;
        out_ready = 1'b0;
      end else begin
        rst = 1'b0;
      end
      @(posedge clk);
      #1;
    end

    // drain: nothing new offered, consumer always ready
    req_valid = '0;
    out_ready = 1'b1;
    rst       = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_queue_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
